pwm_update_sequencer: RTL and testbench

PWM_UPDATE_SEQUENCER -- requirements
Module: pwm_update_sequencer

---
 rtl/pwm_update_sequencer.sv | 152 +++++++++++++++
 tb/tb_pwm_update_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_update_sequencer.sv
// Avalon-MM controlled PWM duty sequencer: shadow/active duty registers with
// sync-aligned transfers, bootstrap precharge, and latched fault shutdown.
module pwm_update_sequencer #(
   parameter int PRECHARGE_CYC = 5000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   input  logic        pwm_sync,
   input  logic        fault_in,
   output logic [15:0] duty_a,
   output logic [15:0] duty_b,
   output logic [15:0] duty_c,
   output logic        drive_en,
   output logic        force_low,
   output logic        irq
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_PRECHARGE = 2'd1;
   localparam logic [1:0] S_RUN       = 2'd2;
   localparam logic [1:0] S_FAULT     = 2'd3;

   localparam int CW = (PRECHARGE_CYC > 1) ? $clog2(PRECHARGE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(PRECHARGE_CYC - 1);

   logic [1:0]    state;
   logic [1:0]    state_nx;
   logic [CW-1:0] cnt;
   logic [15:0]   shadow_a, shadow_b, shadow_c, max_duty;
   logic          commit_pending;
   logic          fault_latched;
   logic          load_active;

   logic wr_ctrl;
   logic arm, disarm, commit, clr_fault;
   logic unused_wdata;

   assign wr_ctrl      = avs_write && (avs_address == 3'd3);
   assign arm          = wr_ctrl && avs_writedata[0];
   assign disarm       = wr_ctrl && avs_writedata[1];
   assign commit       = wr_ctrl && avs_writedata[2];
   assign clr_fault    = wr_ctrl && avs_writedata[3];
   assign unused_wdata = ^avs_writedata[31:16];

   function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   // fault_in overrides every other request; disarm beats arm.
   always_comb begin
      state_nx    = state;
      load_active = 1'b0;
      if (fault_in) begin
         state_nx = S_FAULT;
      end else begin
         case (state)
            S_IDLE: if (arm && !disarm) state_nx = S_PRECHARGE;
            S_PRECHARGE: begin
               if (disarm) begin
                  state_nx = S_IDLE;
               end else if (cnt == '0 && pwm_sync) begin
                  state_nx    = S_RUN;
                  load_active = 1'b1;
               end
            end
            S_RUN: begin
               if (disarm) state_nx = S_IDLE;
               else if (pwm_sync && commit_pending) load_active = 1'b1;
            end
            default: if (clr_fault) state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         commit_pending <= 1'b0;
         fault_latched  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && state_nx == S_PRECHARGE) cnt <= CNT_LOAD;
         else if (state_nx != S_PRECHARGE)               cnt <= '0;
         else if (cnt != '0)                             cnt <= cnt - 1'b1;
         // A commit landing on a transferring sync stays pending for the next one.
         if (commit && !fault_in)  commit_pending <= 1'b1;
         else if (load_active)     commit_pending <= 1'b0;
         if (fault_in)             fault_latched <= 1'b1;
         else if (clr_fault)       fault_latched <= 1'b0;
      end
   end

   // Active duties are only nonzero in RUN, so they drive the outputs directly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_a <= '0;
         duty_b <= '0;
         duty_c <= '0;
      end else if (state_nx != S_RUN) begin
         duty_a <= '0;
         duty_b <= '0;
         duty_c <= '0;
      end else if (load_active) begin
         duty_a <= clamp(shadow_a, max_duty);
         duty_b <= clamp(shadow_b, max_duty);
         duty_c <= clamp(shadow_c, max_duty);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_a <= '0;
         shadow_b <= '0;
         shadow_c <= '0;
         max_duty <= 16'hFFFF;
      end else if (avs_write) begin
         case (avs_address)
            3'd0:    shadow_a <= avs_writedata[15:0];
            3'd1:    shadow_b <= avs_writedata[15:0];
            3'd2:    shadow_c <= avs_writedata[15:0];
            3'd5:    max_duty <= avs_writedata[15:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         avs_readdata <= '0;
      end else if (avs_read) begin
         case (avs_address)
            3'd0:    avs_readdata <= {16'd0, shadow_a};
            3'd1:    avs_readdata <= {16'd0, shadow_b};
            3'd2:    avs_readdata <= {16'd0, shadow_c};
            3'd4:    avs_readdata <= {27'd0, fault_in, fault_latched, commit_pending, state};
            3'd5:    avs_readdata <= {16'd0, max_duty};
            default: avs_readdata <= '0;
         endcase
      end
   end

   assign drive_en  = (state == S_PRECHARGE) || (state == S_RUN);
   assign force_low = (state == S_PRECHARGE);
   assign irq       = fault_latched;

endmodule

// File: tb/tb_pwm_update_sequencer.sv
// Self-checking bench for pwm_update_sequencer: register access, precharge/run
// sequencing, clamp, sync collisions, fault handling and asynchronous reset.
module tb_pwm_update_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  avs_address;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        pwm_sync;
   logic        fault_in;
   logic [15:0] duty_a, duty_b, duty_c;
   logic        drive_en, force_low, irq;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   pwm_update_sequencer #(.PRECHARGE_CYC(4)) dut (
      .clk(clk), .reset(reset),
      .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
      .avs_read(avs_read), .avs_readdata(avs_readdata),
      .pwm_sync(pwm_sync), .fault_in(fault_in),
      .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
      .drive_en(drive_en), .force_low(force_low), .irq(irq)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got %0d compared / %0d mismatched", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] addr, input logic [31:0] data, input logic sync);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      pwm_sync      = sync;
      tick();
      avs_write = 1'b0;
      pwm_sync  = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [2:0] addr, input logic [31:0] exp);
      avs_address = addr;
      avs_read    = 1'b1;
      exp_q.push_back(exp);
      tick();
      avs_read = 1'b0;
      check_eq(tag, avs_readdata, exp_q.pop_front());
   endtask

   task automatic sync_pulse();
      pwm_sync = 1'b1;
      tick();
      pwm_sync = 1'b0;
   endtask

   task automatic arm_to_run();
      bus_write(3'd3, 32'h1, 1'b0);
      repeat (3) tick();
      sync_pulse();
   endtask

   initial begin
      reset = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
      avs_read = 1'b0; pwm_sync = 1'b0; fault_in = 1'b0;
      #1;
      check_eq("rst_drive_en", {31'd0, drive_en}, 32'd0);
      check_eq("rst_force_low", {31'd0, force_low}, 32'd0);
      check_eq("rst_irq", {31'd0, irq}, 32'd0);
      check_eq("rst_duty_a", {16'd0, duty_a}, 32'd0);
      check_eq("rst_readdata", avs_readdata, 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      tick();

      bus_read("status_rst", 3'd4, 32'd0);
      bus_read("maxduty_rst", 3'd5, 32'h0000FFFF);
      bus_read("addr6", 3'd6, 32'd0);
      bus_write(3'd7, 32'h1234, 1'b0);
      bus_read("addr7", 3'd7, 32'd0);

      // Arm sequence: four precharge cycles, an early sync must be ignored.
      bus_write(3'd0, 32'd1000, 1'b0);
      bus_read("shadow_a", 3'd0, 32'd1000);
      bus_write(3'd3, 32'h1, 1'b0);
      check_eq("pre1_force_low", {31'd0, force_low}, 32'd1);
      check_eq("pre1_drive_en", {31'd0, drive_en}, 32'd1);
      tick();
      check_eq("pre2_force_low", {31'd0, force_low}, 32'd1);
      sync_pulse();
      check_eq("pre3_force_low", {31'd0, force_low}, 32'd1);
      check_eq("pre3_duty_a", {16'd0, duty_a}, 32'd0);
      tick();
      check_eq("pre4_force_low", {31'd0, force_low}, 32'd1);
      sync_pulse();
      check_eq("run_force_low", {31'd0, force_low}, 32'd0);
      check_eq("run_duty_a", {16'd0, duty_a}, 32'd1000);
      bus_read("status_run", 3'd4, 32'd2);

      // Clamp against MAX_DUTY.
      bus_write(3'd5, 32'd800, 1'b0);
      bus_write(3'd1, 32'd900, 1'b0);
      bus_write(3'd3, 32'h4, 1'b0);
      bus_read("status_pend", 3'd4, 32'd6);
      check_eq("hold_duty_b", {16'd0, duty_b}, 32'd0);
      sync_pulse();
      check_eq("clamp_duty_b", {16'd0, duty_b}, 32'd800);
      check_eq("clamp_duty_a", {16'd0, duty_a}, 32'd800);
      bus_read("status_clr", 3'd4, 32'd2);

      // Collisions: COMMIT with sync stays pending; shadow write with sync transfers old value.
      bus_write(3'd2, 32'd200, 1'b0);
      bus_write(3'd3, 32'h4, 1'b0);
      bus_write(3'd3, 32'h4, 1'b1);
      check_eq("coll_duty_c", {16'd0, duty_c}, 32'd200);
      bus_read("coll_pending", 3'd4, 32'd6);
      bus_write(3'd2, 32'd300, 1'b0);
      bus_write(3'd2, 32'd500, 1'b1);
      check_eq("old_shadow_c", {16'd0, duty_c}, 32'd300);
      bus_read("coll_status", 3'd4, 32'd2);
      bus_write(3'd3, 32'h4, 1'b0);
      sync_pulse();
      check_eq("next_duty_c", {16'd0, duty_c}, 32'd500);
      bus_write(3'd0, 32'd100, 1'b0);
      sync_pulse();
      check_eq("no_commit_duty_a", {16'd0, duty_a}, 32'd800);

      // DISARM and ARM together in RUN.
      bus_write(3'd3, 32'h3, 1'b0);
      check_eq("disarm_drive_en", {31'd0, drive_en}, 32'd0);
      check_eq("disarm_duty_a", {16'd0, duty_a}, 32'd0);
      check_eq("disarm_duty_c", {16'd0, duty_c}, 32'd0);
      bus_read("disarm_status", 3'd4, 32'd0);

      // Re-arm loads shadows on RUN entry even without a pending commit.
      arm_to_run();
      check_eq("rearm_drive_en", {31'd0, drive_en}, 32'd1);
      check_eq("rearm_duty_a", {16'd0, duty_a}, 32'd100);
      check_eq("rearm_duty_c", {16'd0, duty_c}, 32'd500);

      // Fault in RUN.
      fault_in = 1'b1;
      tick();
      check_eq("fault_drive_en", {31'd0, drive_en}, 32'd0);
      check_eq("fault_duty_c", {16'd0, duty_c}, 32'd0);
      check_eq("fault_irq", {31'd0, irq}, 32'd1);
      bus_write(3'd3, 32'h8, 1'b0);
      bus_read("fault_stuck", 3'd4, 32'h1B);
      fault_in = 1'b0;
      tick();
      check_eq("fault_latched_irq", {31'd0, irq}, 32'd1);
      bus_write(3'd3, 32'h1, 1'b0);
      bus_read("fault_arm_ign", 3'd4, 32'h0B);
      bus_write(3'd3, 32'h8, 1'b0);
      check_eq("clr_irq", {31'd0, irq}, 32'd0);
      bus_read("clr_status", 3'd4, 32'd0);

      // Asynchronous reset mid-RUN takes effect before the next clock edge.
      arm_to_run();
      check_eq("run2_duty_a", {16'd0, duty_a}, 32'd100);
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_drive_en", {31'd0, drive_en}, 32'd0);
      check_eq("async_duty_a", {16'd0, duty_a}, 32'd0);
      check_eq("async_duty_c", {16'd0, duty_c}, 32'd0);
      check_eq("async_force_low", {31'd0, force_low}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      bus_read("post_rst_status", 3'd4, 32'd0);
      bus_read("post_rst_max", 3'd5, 32'h0000FFFF);
      bus_read("post_rst_shadow", 3'd0, 32'd0);

      // final report
      check_eq("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
